// File: rtl/example_arb.sv
// example_arb: two-requester round-robin arbiter feeding one registered output slot.
// Optional macro EXAMPLE_ARB_OR_MERGE_EN: simultaneous requests are OR-merged
// into a single transfer tagged 2'b11 instead of being arbitrated.
module example_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             z_valid,
   output logic [WIDTH-1:0] z_data,
   output logic [1:0]       z_src,
   input  logic             z_ready,
   output logic [15:0]      xfer_cnt
);

   localparam int unsigned CNT_W = 16;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;

   localparam logic [1:0] SRC_A = 2'b01;
   localparam logic [1:0] SRC_B = 2'b10;
   localparam logic [1:0] SRC_M = 2'b11;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_src;
   logic             r_last;
   logic [CNT_W-1:0] r_cnt;

   logic [0:0]       w_state_nxt;
   logic [WIDTH-1:0] w_data_nxt;
   logic [1:0]       w_src_nxt;
   logic             w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_can_load;
   logic             w_xfer;
   logic             w_merge;
   logic             w_a_acc;
   logic             w_b_acc;

   assign w_can_load = (r_state == ST_EMPTY) | z_ready;
   assign w_xfer     = (r_state == ST_FULL) & z_ready;

   // Requester readies: slot can take a word and the pointer favours this side
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      w_merge = 1'b0;
`ifdef EXAMPLE_ARB_OR_MERGE_EN
      a_ready = w_can_load & ~rst;
      b_ready = w_can_load & ~rst;
      w_merge = w_can_load & ~rst & a_valid & b_valid;
`else
      a_ready = w_can_load & ~rst & (~b_valid | (r_last == LAST_B));
      b_ready = w_can_load & ~rst & (~a_valid | (r_last == LAST_A));
`endif
   end

   assign w_a_acc = a_valid & a_ready;
   assign w_b_acc = b_valid & b_ready;

   // Next slot contents, pointer and handshake count
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_src_nxt   = r_src;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt + CNT_W'(w_xfer);
      if (w_merge) begin
         w_state_nxt = ST_FULL;
         w_data_nxt  = a_data | b_data;
         w_src_nxt   = SRC_M;
      end else if (w_a_acc) begin
         w_state_nxt = ST_FULL;
         w_data_nxt  = a_data;
         w_src_nxt   = SRC_A;
         w_last_nxt  = LAST_A;
      end else if (w_b_acc) begin
         w_state_nxt = ST_FULL;
         w_data_nxt  = b_data;
         w_src_nxt   = SRC_B;
         w_last_nxt  = LAST_B;
      end else if (w_xfer) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   // Slot and counter registers; reset discards any held word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
         r_src   <= 2'b00;
         r_last  <= LAST_B;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_src   <= w_src_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign z_valid  = (r_state == ST_FULL);
   assign z_data   = r_data;
   assign z_src    = r_src;
   assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_example_arb.sv
// tb_example_arb: randomized + directed bench with a queue scoreboard for example_arb.
module tb_example_arb;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         a_valid;
   logic [W-1:0] a_data;
   logic         a_ready;
   logic         b_valid;
   logic [W-1:0] b_data;
   logic         b_ready;
   logic         z_valid;
   logic [W-1:0] z_data;
   logic [1:0]   z_src;
   logic         z_ready;
   logic [15:0]  xfer_cnt;

   typedef struct {
      logic [W-1:0] d;
      logic [1:0]   s;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   logic        m_full;
   logic        m_last_b;
   logic [15:0] m_cnt;

   example_arb #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .z_valid(z_valid), .z_data(z_data), .z_src(z_src), .z_ready(z_ready),
      .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every output handshake must match the oldest expected word
   always @(negedge clk) begin
      if (!rst && z_valid && z_ready) begin
         if (exp_q.size() == 0) begin
            chk("z_unexpected_word", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("z_data", 32'(z_data), 32'(e.d));
            chk("z_src", 32'(z_src), 32'(e.s));
         end
      end
   end

   // One clock cycle: drive inputs, check readies/state against the model, advance the model
   task automatic step(input logic r, input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic zr);
      logic can, ear, ebr, mrg, hs;
      exp_t e;
      @(posedge clk);
      #1;
      rst     = r;
      a_valid = av;
      a_data  = ad;
      b_valid = bv;
      b_data  = bd;
      z_ready = r ? 1'b0 : zr;
      #1;
      can = !m_full || z_ready;
`ifdef EXAMPLE_ARB_OR_MERGE_EN
      ear = can && !r;
      ebr = can && !r;
      mrg = ear && av && bv;
`else
      ear = can && !r && (!bv || m_last_b);
      ebr = can && !r && (!av || !m_last_b);
      mrg = 1'b0;
`endif
      chk("a_ready", 32'(a_ready), 32'(ear));
      chk("b_ready", 32'(b_ready), 32'(ebr));
      chk("z_valid", 32'(z_valid), 32'(m_full));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
      hs = m_full && z_ready;
      if (r) begin
         m_full   = 1'b0;
         m_last_b = 1'b1;
         m_cnt    = 16'd0;
         exp_q.delete();
      end else begin
         if (hs) m_cnt = m_cnt + 16'd1;
         if (mrg) begin
            e.d = ad | bd; e.s = 2'b11; exp_q.push_back(e);
            m_full = 1'b1;
         end else if (av && ear) begin
            e.d = ad; e.s = 2'b01; exp_q.push_back(e);
            m_full = 1'b1; m_last_b = 1'b0;
         end else if (bv && ebr) begin
            e.d = bd; e.s = 2'b10; exp_q.push_back(e);
            m_full = 1'b1; m_last_b = 1'b1;
         end else if (hs) begin
            m_full = 1'b0;
         end
      end
   endtask

   initial begin
      m_full   = 1'b0;
      m_last_b = 1'b1;
      m_cnt    = 16'd0;
      rst      = 1'b1;
      a_valid  = 1'b0;
      a_data   = '0;
      b_valid  = 1'b0;
      b_data   = '0;
      z_ready  = 1'b0;
      repeat (2) @(posedge clk);

      // Reset with both requesters valid, then first post-reset cycle
      step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
      step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
      chk("reset_z_data", 32'(z_data), 32'h0);
      step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
      chk("post_reset_a_ready", 32'(a_ready), 32'd1);
      chk("post_reset_b_ready", 32'(b_ready), 32'd0);

      // Contention: alternating A,B,A,B
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("contention_cnt", 32'(xfer_cnt), 32'd4);

      // Backpressure: A word held while B waits
      step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
         chk("bp_b_ready", 32'(b_ready), 32'd0);
         chk("bp_z_data", 32'(z_data), 32'h5A);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
      chk("bp_release_b_ready", 32'(b_ready), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("bp_b_word", 32'(z_data), 32'hC3);
      chk("bp_b_src", 32'(z_src), 32'h2);

      // Reset while the slot is full
      step(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("full_z_data", 32'(z_data), 32'h33);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("midreset_z_valid", 32'(z_valid), 32'd0);
      chk("midreset_z_data", 32'(z_data), 32'h0);
      chk("midreset_cnt", 32'(xfer_cnt), 32'h0);

`ifdef EXAMPLE_ARB_OR_MERGE_EN
      // Merge of simultaneous requests
      step(1'b0, 1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1);
      chk("merge_a_ready", 32'(a_ready), 32'd1);
      chk("merge_b_ready", 32'(b_ready), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("merge_z_data", 32'(z_data), 32'hFF);
      chk("merge_z_src", 32'(z_src), 32'h3);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
              ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
      end

      // Counter wrap: single requester streaming every cycle
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 65538; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
         if (i == 65536) chk("cnt_at_ffff", 32'(xfer_cnt), 32'hFFFF);
         if (i == 65537) chk("cnt_wrap", 32'(xfer_cnt), 32'h0);
      end

      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("scoreboard_depth", 32'(exp_q.size()), 32'(m_full));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/example_arb.md
# example_arb

Two-requester arbiter that shares one output channel between requesters `a` and `b`, the two sources that feed the block's `a|b` combine path. Each requester offers a WIDTH-bit word on a valid/ready handshake. The arbiter grants round-robin into a single registered output slot and drives one downstream valid/ready channel. An optional compile-time mode merges simultaneous requests into one OR-combined transfer.

## Interface
- `WIDTH`, default 8: data width of both requesters and the output.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `a_valid`  in  1  requester A offers `a_data`.
- `a_data`  in  WIDTH  requester A word.
- `a_ready`  out  1  A word accepted this cycle when high with `a_valid`.
- `b_valid`  in  1  requester B offers `b_data`.
- `b_data`  in  WIDTH  requester B word.
- `b_ready`  out  1  B word accepted this cycle when high with `b_valid`.
- `z_valid`  out  1  output slot holds a word.
- `z_data`  out  WIDTH  output word.
- `z_src`  out  2  source tag of output word: 01 = A, 10 = B, 11 = merged.
- `z_ready`  in  1  downstream accepts `z_data` this cycle.
- `xfer_cnt`  out  16  count of completed output handshakes.

## Operation
- Output slot states:
  - EMPTY: `z_valid`=0.
  - FULL: `z_valid`=1.
- `can_load` = EMPTY | (FULL & `z_ready`). A slot draining this cycle is reloaded in the same cycle.
- Last-grant pointer `last` ∈ {A,B}; reset value B, so A wins the first contest.
- `a_ready` = `can_load` & ~`rst` & (~`b_valid` | `last`==B).
- `b_ready` = `can_load` & ~`rst` & (~`a_valid` | `last`==A).
- A ready never depends on its own valid.
- Accept (valid & ready on a requester):
  - Slot loads that requester's data.
  - `z_src` is set to its tag.
  - `z_valid` goes to 1.
  - `last` is set to that requester.
- FULL & `z_ready` & no accept → EMPTY.
- FULL & ~`z_ready` → hold. `z_data`, `z_src` and `z_valid` stay unchanged and both readys are 0.
- `xfer_cnt` increments on every `z_valid`&`z_ready`. It wraps 0xFFFF→0x0000.
- Reset values: `z_valid`=0, `z_data`=0, `z_src`=00, `xfer_cnt`=0, `last`=B, `a_ready`=`b_ready`=0.
- Reset asserted while FULL discards the held word; no handshake is counted.

## Timing
- Input accept to `z_valid`: 1 cycle (registered slot).
- Throughput: one word per cycle while `z_ready` stays high.
- Both requesters continuously valid with `z_ready`=1: grants alternate A,B,A,B…, one per cycle.
- A single active requester is granted every cycle; no dead cycle on pointer mismatch.
- `z_ready` may toggle freely; output is stable under backpressure.
- First cycle after `rst` deasserts: readys may assert if valids are present.

## Configuration
- Macro `EXAMPLE_ARB_OR_MERGE_EN`.
- Defined: when `can_load` & `a_valid` & `b_valid`:
  - Both readys are 1.
  - Slot loads `a_data|b_data`.
  - `z_src`=11.
  - `last` is unchanged.
  - `xfer_cnt` counts the merged word once.
  - Single-requester cycles behave as in the base mode.
- Undefined: round-robin only; `z_src` never equals 11.

## Test plan
- Reset:
  - Stimulus: drive `rst`=1 for 2 cycles with `a_valid`=`b_valid`=1, then release.
  - Response during reset: both readys 0, `z_valid`=0, `xfer_cnt`=0.
  - Response on the first post-reset cycle: `a_ready`=1, `b_ready`=0.
- Contention (macro undefined):
  - Stimulus: `a_data`=0x11, `b_data`=0x22, both valid for 4 cycles, `z_ready`=1.
  - Response: `z_data` sequence 0x11,0x22,0x11,0x22 with `z_src` 01,10,01,10; `xfer_cnt`=4.
- Backpressure:
  - Stimulus: A sends 0x5A; hold `z_ready`=0 for 3 cycles, with `b_valid`=1 throughout.
  - Response while held: `z_data`=0x5A stable, `b_ready`=0.
  - Response on `z_ready`=1: the same cycle `b_ready`=1, and B's word appears next cycle.
- Counter wrap:
  - Stimulus: preload via 65535 transfers, then 1 more.
  - Response: `xfer_cnt` goes 0xFFFF→0x0000.
- Reset mid-operation:
  - Stimulus: slot FULL with 0x33, `z_ready`=0, then `rst`=1.
  - Response: next cycle `z_valid`=0, `z_data`=0, `xfer_cnt` unchanged-then-0.
- Merge (macro defined):
  - Stimulus: `a_data`=0x0F, `b_data`=0xF0, both valid one cycle.
  - Response: both readys 1, `z_data`=0xFF, `z_src`=11, `xfer_cnt`+1.
